// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: ALU opcodes plus the divider state encoding
// and sizing constants.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_state_e;

  localparam int DIV_CNT_WIDTH = $clog2(XLEN) + 1;
  localparam int DIV_LATENCY   = XLEN + 1;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle. Define DIV_EARLY_OUT_EN to skip the iterations for /0 and overflow.
//
// state  | meaning
// IDLE   | waiting for start with a divide op; latches operands
// CALC   | one restoring step per cycle, XLEN steps
// FINISH | sign fix-up and special cases, registers result, pulses done
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [DIV_CNT_WIDTH-1:0] LAST_STEP = DIV_CNT_WIDTH'(XLEN - 1);

  div_state_e               state_q;
  alu_op_e                  op_q;
  logic [XLEN-1:0]          a_q, b_q, rem_q, quo_q, result_q;
  logic [DIV_CNT_WIDTH-1:0] cnt_q;
  logic                     busy_q, done_q;

  logic                     op_signed, op_rem, b_zero, ovf;
  logic [XLEN-1:0]          b_mag, quo_fix, rem_fix, result_d;
  logic [XLEN:0]            rem_shift, rem_sub;
  logic                     rem_ge;
  logic [XLEN-1:0]          rem_d, quo_d;
  logic                     in_signed, in_special;
  logic [XLEN-1:0]          a_mag_in;

  always_comb begin
    op_signed = is_signed_div_op(op_q);
    op_rem    = (op_q == ALU_REM) || (op_q == ALU_REMU);
    b_mag     = (op_signed && b_q[XLEN-1]) ? -b_q : b_q;
    // Keep the remainder's top bit in the shift: unsigned divisors near 2^XLEN
    // leave partial remainders that need XLEN+1 bits after shifting.
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_ge    = rem_shift >= {1'b0, b_mag};
    rem_sub   = rem_shift - {1'b0, b_mag};
    rem_d     = rem_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], rem_ge};

    b_zero    = (b_q == '0);
    ovf       = op_signed && (a_q == INT_MIN) && (b_q == '1);
    quo_fix   = (op_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    rem_fix   = (op_signed && a_q[XLEN-1]) ? -rem_q : rem_q;

    result_d = op_rem ? rem_fix : quo_fix;
    if (b_zero)   result_d = op_rem ? a_q : '1;
    else if (ovf) result_d = op_rem ? '0 : INT_MIN;

    in_signed  = is_signed_div_op(op);
    a_mag_in   = (in_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
    in_special = (operand_b == '0) ||
                 (in_signed && (operand_a == INT_MIN) && (operand_b == '1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && is_div_op(op)) begin
              op_q   <= op;
              a_q    <= operand_a;
              b_q    <= operand_b;
              rem_q  <= '0;
              quo_q  <= a_mag_in;
              cnt_q  <= '0;
              busy_q <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
              state_q <= in_special ? FINISH : CALC;
`else
              state_q <= CALC;
`endif
            end
          end
          CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) state_q <= FINISH;
          end
          FINISH: begin
            result_q <= result_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifndef DIV_EARLY_OUT_EN
  logic unused_special;
  assign unused_special = in_special;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus flush, busy-start,
// illegal-op and mid-operation reset sequences.
module tb_div_unit;
  import riscv_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif
  localparam int NORMAL_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  alu_op_e     op = ALU_ADD;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input alu_op_e o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 60);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (done) n++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    issue(v.op, v.a, v.b);
    check({name, " busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({name, " latency"}, lat, v.special ? SPECIAL_LAT : NORMAL_LAT);
    check({name, " result"}, result, v.exp);
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1 check({name, " done_single_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, nd;
    logic [31:0] prev;

    vecs[0]  = '{ALU_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{ALU_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{ALU_REMU, 32'd5,          32'd0,          32'd5,          1'b1};
    vecs[6]  = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[7]  = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[8]  = '{ALU_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[9]  = '{ALU_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[10] = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[11] = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[12] = '{ALU_DIVU, 32'h8000_0000,  32'd7,          32'h1249_2492,  1'b0};
    vecs[13] = '{ALU_REM,  32'h8000_0000,  32'd7,          32'hFFFF_FFFE,  1'b0};
    vecs[14] = '{ALU_DIVU, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[15] = '{ALU_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Flush ten cycles into DIVU 9/3: no done, result keeps the last value.
    prev = result;
    issue(ALU_DIVU, 32'd9, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush busy_drop", 32'(busy), 32'd0);
    check("flush no_done", 32'(done), 32'd0);
    count_dones(40, nd);
    check("flush done_count", nd, 0);
    check("flush result_held", result, prev);
    run_vec("after_flush", '{ALU_DIVU, 32'd9, 32'd3, 32'd3, 1'b0});

    // Flush wins over a simultaneous start in IDLE.
    @(negedge clk);
    op = ALU_DIVU; operand_a = 32'd50; operand_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    check("flush_vs_start busy", 32'(busy), 32'd0);

    // start while busy is ignored.
    issue(ALU_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = ALU_DIVU; operand_a = 32'd1; operand_b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check("busy_start latency", lat, NORMAL_LAT - 6);
    check("busy_start result", result, 32'd14);
    count_dones(40, nd);
    check("busy_start extra_done", nd, 0);

    // Non-divide op in IDLE is ignored.
    issue(ALU_ADD, 32'd3, 32'd4);
    check("alu_add busy", 32'(busy), 32'd0);
    count_dones(40, nd);
    check("alu_add done_count", nd, 0);
    check("alu_add result", result, 32'd14);

    // Reset mid-operation aborts with no done and clears result.
    issue(ALU_DIVU, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    count_dones(40, nd);
    check("midreset done_count", nd, 0);
    run_vec("after_reset", '{ALU_DIVU, 32'd100, 32'd3, 32'd33, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out, got no finish expected finish");
    $fatal(1);
  end

endmodule
